// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: widths and FSM state encoding.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;

    typedef enum logic [1:0] {
        StIdle = DIV_IDLE,
        StRun  = DIV_RUN,
        StFix  = DIV_FIX
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on {rem,quo} against an unsigned divisor.
// Purely combinational.
module div_step import div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Shift {rem,quo} left, subtract divisor when it fits, set quotient bit accordingly.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        fits     = shifted >= {1'b0, divisor};
        // When fits, the true difference is below divisor, so modulo-2^WIDTH is exact.
        diff     = shifted[WIDTH-1:0] - divisor;
        rem_next = fits ? diff : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative signed divider (MIPS div) for the multicycle datapath.
// Optional macro DIV_UNSIGNED_EN adds the divu input for MIPS divu.
module div_unit import div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             CtoD,
`ifdef DIV_UNSIGNED_EN
    input  logic             divu,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             DtoC,
    output logic             DivZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, divisor_q, divisor_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic             done_q, done_d, divzero_q, divzero_d;

    logic             is_unsigned;
    logic [WIDTH-1:0] abs_a, abs_b, step_rem, step_quo;
    logic             last_step;

`ifdef DIV_UNSIGNED_EN
    assign is_unsigned = divu;
`else
    assign is_unsigned = 1'b0;
`endif

    // Magnitudes; negating 0x80000000 yields itself, read as unsigned 2^(WIDTH-1).
    assign abs_a = (!is_unsigned && a[WIDTH-1]) ? -a : a;
    assign abs_b = (!is_unsigned && b[WIDTH-1]) ? -b : b;

    // The counter reaches WIDTH on one extra RUN cycle, giving the fixed WIDTH+2 latency.
    assign last_step = (cnt_q == CntW'(WIDTH));

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (CtoD && (b != '0)) state_d = StRun;
            StRun:   if (last_step)         state_d = StFix;
            StFix:                          state_d = StIdle;
            default:                        state_d = StIdle;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (CtoD) begin
                    if (b == '0) begin
                        done_d    = 1'b1;
                        divzero_d = 1'b1;
                    end else begin
                        divisor_d = abs_b;
                        quo_d     = abs_a;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = !is_unsigned && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = !is_unsigned && a[WIDTH-1];
                    end
                end
            end
            StRun: begin
                if (!last_step) begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFix: begin
                lo_d   = neg_quo_q ? -quo_q : quo_q;
                hi_d   = neg_rem_q ? -rem_q : rem_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign DtoC    = done_q;
    assign DivZero = divzero_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (default build, signed divide only).
module tb_div_unit;

    logic        clock;
    logic        reset;
    logic        CtoD;
    logic [31:0] a;
    logic [31:0] b;
    logic        DtoC;
    logic        DivZero;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run;
    int tests_failed;

    div_unit #(
        .WIDTH (32)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .CtoD    (CtoD),
        .a       (a),
        .b       (b),
        .DtoC    (DtoC),
        .DivZero (DivZero),
        .hi      (hi),
        .lo      (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts a divide, then watches 60 cycles after the sampling edge E0.
    // lat is the index k of the edge E_k after which DtoC is first seen.
    task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input int inj_at, input int rst_at, input int exp_pulses,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input logic exp_dz, input int exp_lat);
        int   pulses;
        int   lat;
        logic dz_at_pulse;
        logic [31:0] lo_at_pulse;
        logic [31:0] hi_at_pulse;
        pulses      = 0;
        lat         = -1;
        dz_at_pulse = 1'b0;
        lo_at_pulse = '0;
        hi_at_pulse = '0;
        @(negedge clock);
        a    = av;
        b    = bv;
        CtoD = 1'b1;
        @(posedge clock);
        #1;
        CtoD = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (DtoC) begin
                pulses++;
                if (lat < 0) begin
                    lat         = k;
                    dz_at_pulse = DivZero;
                    lo_at_pulse = lo;
                    hi_at_pulse = hi;
                end
            end
            if (k == inj_at) begin
                a    = 32'd1;
                b    = 32'd1;
                CtoD = 1'b1;
            end
            if (k == inj_at + 1) CtoD = 1'b0;
            if (k == rst_at) reset = 1'b1;
            if (k == rst_at + 1) reset = 1'b0;
            @(posedge clock);
            #1;
        end
        check($sformatf("%s.pulses", tag), pulses, exp_pulses);
        if (exp_pulses > 0) begin
            check($sformatf("%s.latency", tag), lat, exp_lat);
            check($sformatf("%s.divzero", tag), {31'd0, dz_at_pulse}, {31'd0, exp_dz});
            check($sformatf("%s.lo_at_done", tag), lo_at_pulse, exp_lo);
            check($sformatf("%s.hi_at_done", tag), hi_at_pulse, exp_hi);
        end
        check($sformatf("%s.lo_held", tag), lo, exp_lo);
        check($sformatf("%s.hi_held", tag), hi, exp_hi);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1;
        CtoD  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset.hi", hi, 32'd0);
        check("reset.lo", lo, 32'd0);
        check("reset.dtoc", {31'd0, DtoC}, 32'd0);
        check("reset.divzero", {31'd0, DivZero}, 32'd0);
        reset = 1'b0;

        run_div("7/2",      32'd7,        32'd2,        -1, -1, 1, 32'd3,        32'd1,        1'b0, 34);
        run_div("-7/2",     32'hFFFFFFF9, 32'd2,        -1, -1, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
        run_div("7/-2",     32'd7,        32'hFFFFFFFE, -1, -1, 1, 32'hFFFFFFFD, 32'd1,        1'b0, 34);
        run_div("100/7",    32'd100,      32'd7,        -1, -1, 1, 32'd14,       32'd2,        1'b0, 34);
        run_div("5/0",      32'd5,        32'd0,        -1, -1, 1, 32'd14,       32'd2,        1'b1, 0);
        run_div("min/-1",   32'h80000000, 32'hFFFFFFFF, -1, -1, 1, 32'h80000000, 32'd0,        1'b0, 34);
        run_div("ignored",  32'd100,      32'd7,        10, -1, 1, 32'd14,       32'd2,        1'b0, 34);
        run_div("abort",    32'd1000,     32'd3,        -1, 10, 0, 32'd0,        32'd0,        1'b0, 0);
        run_div("9/3",      32'd9,        32'd3,        -1, -1, 1, 32'd3,        32'd0,        1'b0, 34);
        run_div("0/5",      32'd0,        32'd5,        -1, -1, 1, 32'd0,        32'd0,        1'b0, 34);
        run_div("-100/-7",  32'hFFFFFF9C, 32'hFFFFFFF9, -1, -1, 1, 32'd14,       32'hFFFFFFFE, 1'b0, 34);
        run_div("min/1",    32'h80000000, 32'd1,        -1, -1, 1, 32'h80000000, 32'd0,        1'b0, 34);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit signed divider for the multicycle MIPS datapath; implements div.
- The main control FSM starts it via the CtoD handshake and waits in its divide-wait state for DtoC.
- Results go to the HI/LO registers, which the control loads in its writeHL state. Divide-by-zero is flagged on DivZero so control can branch to its exception sequence.
- One restoring-division step per cycle.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH, counter width is clog2(WIDTH)+1

Ports:
clock  input  1  system clock; all flops on rising edge
reset  input  1  synchronous, active-high reset
CtoD  input  1  start request from control; sampled only in IDLE
a  input  WIDTH  dividend (rs), sampled with CtoD
b  input  WIDTH  divisor (rt), sampled with CtoD
DtoC  output  1  done pulse to control, exactly one cycle
DivZero  output  1  divide-by-zero flag, one-cycle pulse coincident with DtoC
hi  output  WIDTH  remainder, registered, held until next completed divide
lo  output  WIDTH  quotient, registered, held until next completed divide

Behaviour:
- Reset (synchronous, priority over everything): state=IDLE, hi=0, lo=0, DtoC=0, DivZero=0, internal regs=0. Reset mid-divide aborts; no DtoC is produced.
- IDLE:
  - CtoD=0: stay in IDLE.
  - CtoD=1, b==0: DivZero=1 and DtoC=1 next cycle; hi/lo unchanged; stay IDLE.
  - CtoD=1, b!=0: latch |a|, |b|, sign_q=a[31]^b[31], sign_r=a[31]; remainder=0; count=0; go to RUN.
- RUN: one restoring step per cycle:
  - {rem,quo} shift left 1.
  - trial = rem - |b| (WIDTH+1 bits).
  - trial non-negative: rem=trial, quo[0]=1; else quo[0]=0.
  - count increments; after the WIDTH-th step go to FIX.
- FIX:
  - lo = sign_q ? -quo : quo.
  - hi = sign_r ? -rem : rem.
  - DtoC=1 next cycle; return to IDLE.
- Latency: DtoC is visible for the cycle following edge WIDTH+2 after the start-sampling edge, i.e. 34 cycles for WIDTH=32. Divide-by-zero latency is 1 cycle.
- DtoC and DivZero deassert on the following edge; never high for 2 consecutive cycles.
- CtoD asserted outside IDLE (RUN/FIX) is ignored; it is not queued.
- CtoD held high at return to IDLE starts a new divide in the same cycle DtoC is high; control must drop CtoD on DtoC.
- Semantics match MIPS div: quotient truncates toward zero; remainder takes the dividend's sign.
- Magnitude of 0x80000000 is treated as unsigned 0x80000000.
- 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap, no overflow flag).
- a=0 with b!=0 gives lo=0, hi=0 after the full latency.

Optional Feature:
DIV_UNSIGNED_EN:
- When defined, adds input port divu (1 bit), sampled with CtoD. divu=1 skips the abs/sign handling and implements MIPS divu: unsigned quotient and remainder, same latency, DivZero rule unchanged.
- When undefined, the port is absent and all divides are signed.

Decomposition:
- Shared package div_pkg:
  - state encoding constants DIV_IDLE=2'd0, DIV_RUN=2'd1, DIV_FIX=2'd2.
  - DIV_WIDTH=32.
  - DIV_CNT_W derived from the width.
- Sub-module div_step: purely combinational. Takes {rem,quo} and |b|; returns next rem, next quo. This isolates the restoring iteration for unit test and a possible later 2-steps-per-cycle variant.

Test Plan:
- a=7, b=2, CtoD one cycle -> DtoC high exactly 34 cycles later for one cycle; lo=3, hi=1; DivZero=0.
- a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Repeat with a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
- Preload hi/lo via a 100/7 divide (lo=14, hi=2); then a=5, b=0 -> next cycle DtoC=1 and DivZero=1 for one cycle; hi=2, lo=14 unchanged.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0 at cycle 34.
- Start 100/7; pulse CtoD again at cycle 10 with a=1, b=1 -> single DtoC at cycle 34; lo=14, hi=2 (second request ignored).
- Start a divide; assert reset at cycle 10 -> no DtoC ever; hi=lo=0; a new 9/3 start afterwards gives lo=3, hi=0 with normal latency.
